clock_enable_gen: RTL and testbench
===================================

# clock_enable_gen

Multi-channel, runtime-programmable clock-enable generator; successor to the fixed single-output divider. Each of NUM_CH channels divides the 25 MHz board clock by its own divisor. It outputs a one-cycle tick for use as a clock enable, plus a toggling square wave for LEDs and segment blanking. It sits between the board clock and the game logic (snake step rate, input debounce sampling, display refresh), and all consumers stay in the single clk_in domain.

## Interface
- NUM_CH, 4: number of independent channels (≥1).
- CNT_W, 25: counter/divisor width; divisors up to 2^CNT_W−1.
- DEFAULT_DIV, 25_000_000: reset divisor for every channel (1 Hz tick at 25 MHz); values below 1 are treated as 1.
- SEL_W, max(1,$clog2(NUM_CH)): channel-select width (derived).

- clk_in  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- div_wr  in  1  divisor write strobe, one cycle.
- div_sel  in  SEL_W  channel addressed by div_wr; values ≥ NUM_CH are ignored.
- div_data  in  CNT_W  new divisor; 0 is stored as 1.
- sync_restart  in  1  phase-aligns all channels.
- tick_out  out  NUM_CH  one-cycle pulse every divisor cycles.
- sq_out  out  NUM_CH  square wave; toggles on each tick, so the period is 2×divisor.
- pend_out  out  NUM_CH  a divisor write is held, not yet active.

## Operation
- Per-channel state: cnt[CNT_W], div_act, div_pend, pend flag, tick and sq registers.
- Reset (rst_n low at an edge): cnt=0, div_act=DEFAULT_DIV, pend=0, tick_out=0, sq_out=0, pend_out=0.
- Enabled channel, no restart:
  - If cnt == div_act−1: cnt←0, tick←1, sq←~sq; wrap occurs.
  - Otherwise cnt←cnt+1, tick←0.
- Divisor update, enabled channel: a write sets div_pend and pend. At the next wrap, div_act←div_pend and pend clears.
  - The current period is never truncated or stretched.
  - A write landing in the wrap cycle itself becomes div_act at that wrap, with no pending phase.
  - Repeated writes before the wrap: last write wins.
- Divisor update, disabled channel: the write goes directly to div_act the next cycle. cnt←0, pend stays 0.
- Disabled channel (ch_en low):
  - cnt and sq hold; tick_out is 0.
  - Re-enabling resumes counting from the held cnt.
  - A held pend flag persists until the next wrap.
- sync_restart (highest priority after reset), for every channel regardless of ch_en:
  - cnt←0, sq←0, tick←0.
  - Any pending divisor is applied. A div_wr in the same cycle is applied directly.
- Divisor 1: tick_out is constantly high while enabled; sq_out toggles every cycle (clk_in/2).
- Channels are fully independent; only sync_restart and rst_n act globally.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- First tick after reset release or sync_restart with divisor D: tick_out goes high after the D-th enabled rising edge, for exactly one cycle, then every D cycles.
- sq_out changes on the same edge that raises tick_out.
- div_wr → pend_out high on the next edge; pend_out falls on the wrap edge that applies the divisor.
- The new divisor governs the period starting at that wrap.
- ch_en low→high: counting resumes on the first edge with ch_en high, with no lost or extra count.
- Throughput: one div_wr per cycle is accepted, with no back-pressure.

## Structure
- Shared package clock_enable_pkg holds:
  - CLK_HZ = 25_000_000.
  - Named divisor constants: DIV_1HZ, DIV_SNAKE_STEP, DIV_DEBOUNCE_1KHZ, DIV_REFRESH_200HZ.
  - The CNT_W default.
- Sub-module div_channel: one channel's counter, divisor registers, pend logic, tick and sq.
- The top module handles div_sel decode, the 0→1 clamp and sync_restart fan-out, then generates NUM_CH instances.

## Test plan
- Reset default: DEFAULT_DIV=4, all ch_en=1, rst_n released. Required response:
  - tick_out pulses on edges 4, 8, 12, each one cycle wide.
  - sq_out reads 1 on cycles 4–7, 0 on 8–11, 1 on 12–15.
- Mid-period write: div_act=10; write 3 to channel 1 at cnt=5. Required response:
  - pend_out[1]=1 for 4 cycles.
  - Next tick arrives 10 cycles after the previous one; thereafter ticks are every 3 cycles.
- Wrap-cycle and zero write:
  - Writing 2 in the wrap cycle: the next interval is 2.
  - Writing 0: stored as 1, so tick_out stays high continuously and sq_out toggles every cycle.
- Enable gating: div=5; drop ch_en for 7 cycles at cnt=2. Required response:
  - No tick while ch_en is low; sq_out holds.
  - First tick arrives 3 enabled cycles after re-enable.
  - A write while disabled applies immediately with cnt=0.
- sync_restart: channels at divisors 3/5/7/11, mid-count, assert sync_restart for one cycle. Required response:
  - All sq_out=0 and cnt=0.
  - Channels tick at 3, 5, 7, 11 cycles afterwards.
  - A same-cycle div_wr is honoured.
- Reset mid-operation: assert rst_n low while pend=1 and sq=1. Required response:
  - The next edge gives all outputs 0, pend cleared and div_act=DEFAULT_DIV.
  - Out-of-range div_sel writes have no effect on any channel.

Source files
------------

// File: rtl/clock_enable_pkg.sv
// Shared constants for the clock-enable generator: board clock rate and
// the standard divisors used by the game logic.
package clock_enable_pkg;

   localparam int CLK_HZ        = 25_000_000;
   localparam int DEFAULT_CNT_W = 25;

   localparam int DIV_1HZ           = CLK_HZ;
   localparam int DIV_SNAKE_STEP    = CLK_HZ / 8;
   localparam int DIV_DEBOUNCE_1KHZ = CLK_HZ / 1_000;
   localparam int DIV_REFRESH_200HZ = CLK_HZ / 200;

   // A divisor of zero has no meaningful period, so it behaves as divide-by-1.
   function automatic int clamp_div(input int d);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/clock_enable_gen_div_channel.sv
// One divider channel: counter, active/pending divisor, one-cycle tick and
// square-wave output. All outputs are registered.
module div_channel
   import clock_enable_pkg::*;
#(
   parameter int               CNT_W     = DEFAULT_CNT_W,
   parameter logic [CNT_W-1:0] RESET_DIV = CNT_W'(1)
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             wr,
   input  logic [CNT_W-1:0] data,
   output logic             tick,
   output logic             sq,
   output logic             pend
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_act;
   logic [CNT_W-1:0] div_pend;
   logic             wrap;

   assign wrap = (cnt == div_act - CNT_W'(1));

   // Writes to a running channel wait for the wrap so no period is cut short;
   // a write landing on the wrap itself takes effect immediately.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cnt      <= '0;
         div_act  <= RESET_DIV;
         div_pend <= RESET_DIV;
         pend     <= 1'b0;
         tick     <= 1'b0;
         sq       <= 1'b0;
      end else if (restart) begin
         cnt  <= '0;
         tick <= 1'b0;
         sq   <= 1'b0;
         pend <= 1'b0;
         if (wr)
            div_act <= data;
         else if (pend)
            div_act <= div_pend;
      end else if (en) begin
         if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            sq   <= ~sq;
            pend <= 1'b0;
            if (wr)
               div_act <= data;
            else if (pend)
               div_act <= div_pend;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
            if (wr) begin
               div_pend <= data;
               pend     <= 1'b1;
            end
         end
      end else begin
         tick <= 1'b0;
         if (wr) begin
            div_act <= data;
            cnt     <= '0;
            pend    <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: decodes divisor writes,
// clamps zero divisors and fans sync_restart out to every channel.
module clock_enable_gen
   import clock_enable_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int DEFAULT_DIV = DIV_1HZ,
   parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_data,
   input  logic              sync_restart,
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] sq_out,
   output logic [NUM_CH-1:0] pend_out
);

   localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clamp_div(DEFAULT_DIV));

   logic [CNT_W-1:0]  div_clamped;
   logic [NUM_CH-1:0] wr_vec;

   always_comb begin
      div_clamped = (div_data == '0) ? CNT_W'(1) : div_data;
   end

   // Selects at or beyond NUM_CH match no channel and are dropped.
   always_comb begin
      wr_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (div_wr && (32'(div_sel) == i))
            wr_vec[i] = 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      div_channel #(
         .CNT_W     (CNT_W),
         .RESET_DIV (RESET_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .rst_n   (rst_n),
         .en      (ch_en[g]),
         .restart (sync_restart),
         .wr      (wr_vec[g]),
         .data    (div_clamped),
         .tick    (tick_out[g]),
         .sq      (sq_out[g]),
         .pend    (pend_out[g])
      );
   end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: three channels, 8-bit counters and a
// reset divisor of 4 so every period can be followed by hand.
module tb_clock_enable_gen;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;

   logic              clk_in = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] ch_en;
   logic              div_wr;
   logic [1:0]        div_sel;
   logic [CNT_W-1:0]  div_data;
   logic              sync_restart;
   logic [NUM_CH-1:0] tick_out;
   logic [NUM_CH-1:0] sq_out;
   logic [NUM_CH-1:0] pend_out;

   int checks = 0;
   int errors = 0;

   logic [2:0] expTick;
   logic [2:0] expSq;
   logic [2:0] expPend;
   logic [2:0] enVec;
   logic       base4;
   logic       sq4;

   always #5 clk_in = ~clk_in;

   clock_enable_gen #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (4),
      .SEL_W       (2)
   ) dut (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .ch_en        (ch_en),
      .div_wr       (div_wr),
      .div_sel      (div_sel),
      .div_data     (div_data),
      .sync_restart (sync_restart),
      .tick_out     (tick_out),
      .sq_out       (sq_out),
      .pend_out     (pend_out)
   );

   task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] en, input logic wr, input logic [1:0] sel,
                                input logic [7:0] data, input logic restart);
      ch_en        = en;
      div_wr       = wr;
      div_sel      = sel;
      div_data     = data;
      sync_restart = restart;
   endtask

   task automatic nextCycle();
      @(negedge clk_in);
   endtask

   initial begin
      // Reset and default divisor of 4 on every channel
      rst_n = 1'b0;
      applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
      repeat (2) nextCycle();
      checkOutput("reset tick", tick_out, 3'b000);
      checkOutput("reset sq", sq_out, 3'b000);
      checkOutput("reset pend", pend_out, 3'b000);
      rst_n = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         nextCycle();
         expTick = (k % 4 == 0) ? 3'b111 : 3'b000;
         expSq   = ((k / 4) % 2 == 1) ? 3'b111 : 3'b000;
         checkOutput($sformatf("release tick k=%0d", k), tick_out, expTick);
         checkOutput($sformatf("release sq k=%0d", k), sq_out, expSq);
      end

      // Restart with a same-cycle write of 10 to channel 1, then mid-period,
      // wrap-cycle and zero writes on channel 1
      applyStimulus(3'b111, 1'b1, 2'd1, 8'd10, 1'b1);
      nextCycle();
      checkOutput("restart1 tick", tick_out, 3'b000);
      checkOutput("restart1 sq", sq_out, 3'b000);
      checkOutput("restart1 pend", pend_out, 3'b000);
      applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
      for (int r = 1; r <= 32; r++) begin
         nextCycle();
         base4   = (r % 4 == 0);
         sq4     = ((r / 4) % 2 == 1);
         expTick = {base4, (r inside {10, 13, 16, 19, 22, 24, 26, [28:32]}), base4};
         expSq   = {sq4, (r inside {[10:12], [16:18], [22:23], [26:27], 29, 31}), sq4};
         expPend = {1'b0, (r inside {[6:9], 27}), 1'b0};
         checkOutput($sformatf("ch1 tick r=%0d", r), tick_out, expTick);
         checkOutput($sformatf("ch1 sq r=%0d", r), sq_out, expSq);
         checkOutput($sformatf("ch1 pend r=%0d", r), pend_out, expPend);
         if (r == 5)
            applyStimulus(3'b111, 1'b1, 2'd1, 8'd3, 1'b0);
         else if (r == 21)
            applyStimulus(3'b111, 1'b1, 2'd1, 8'd2, 1'b0);
         else if (r == 26)
            applyStimulus(3'b111, 1'b1, 2'd1, 8'd0, 1'b0);
         else
            applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      // Enable gating on channel 2 at divisor 5, plus a write while disabled
      applyStimulus(3'b111, 1'b1, 2'd2, 8'd5, 1'b1);
      nextCycle();
      checkOutput("restart2 tick", tick_out, 3'b000);
      checkOutput("restart2 sq", sq_out, 3'b000);
      applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
      for (int s = 1; s <= 32; s++) begin
         nextCycle();
         base4   = (s % 4 == 0);
         expTick = {(s inside {5, 17, 22, 29, 32}), 1'b1, base4};
         expSq   = {(s inside {[5:16], [22:28], 32}), (s % 2 == 1), ((s / 4) % 2 == 1)};
         checkOutput($sformatf("gate tick s=%0d", s), tick_out, expTick);
         checkOutput($sformatf("gate sq s=%0d", s), sq_out, expSq);
         checkOutput($sformatf("gate pend s=%0d", s), pend_out, 3'b000);
         enVec = (s inside {[7:13], [24:25]}) ? 3'b011 : 3'b111;
         if (s == 25)
            applyStimulus(enVec, 1'b1, 2'd2, 8'd3, 1'b0);
         else
            applyStimulus(enVec, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      // Program 2/5/13 while disabled, hold a pending 3 on channel 0, then
      // restart with a same-cycle write of 7 to channel 2
      applyStimulus(3'b000, 1'b1, 2'd0, 8'd2, 1'b0);
      nextCycle();
      checkOutput("disabled tick", tick_out, 3'b000);
      checkOutput("disabled pend", pend_out, 3'b000);
      applyStimulus(3'b000, 1'b1, 2'd1, 8'd5, 1'b0);
      nextCycle();
      applyStimulus(3'b000, 1'b1, 2'd2, 8'd13, 1'b0);
      nextCycle();
      applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
      repeat (2) nextCycle();
      checkOutput("div2 tick", tick_out, 3'b001);
      applyStimulus(3'b111, 1'b1, 2'd0, 8'd3, 1'b0);
      nextCycle();
      checkOutput("prerestart pend", pend_out, 3'b001);
      checkOutput("prerestart sq", sq_out, 3'b101);
      applyStimulus(3'b111, 1'b1, 2'd2, 8'd7, 1'b1);
      nextCycle();
      checkOutput("restart3 tick", tick_out, 3'b000);
      checkOutput("restart3 sq", sq_out, 3'b000);
      checkOutput("restart3 pend", pend_out, 3'b000);
      applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
      for (int u = 1; u <= 17; u++) begin
         nextCycle();
         expTick = {(u % 7 == 0), (u % 5 == 0), (u % 3 == 0)};
         expSq   = {((u / 7) % 2 == 1), ((u / 5) % 2 == 1), ((u / 3) % 2 == 1)};
         expPend = (u == 17) ? 3'b001 : 3'b000;
         checkOutput($sformatf("sync tick u=%0d", u), tick_out, expTick);
         checkOutput($sformatf("sync sq u=%0d", u), sq_out, expSq);
         checkOutput($sformatf("sync pend u=%0d", u), pend_out, expPend);
         if (u == 15)
            applyStimulus(3'b111, 1'b1, 2'd3, 8'd1, 1'b0);
         else if (u == 16)
            applyStimulus(3'b111, 1'b1, 2'd0, 8'd5, 1'b0);
         else
            applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      // Reset while channel 0 has pend=1 and sq=1
      rst_n = 1'b0;
      nextCycle();
      checkOutput("midreset tick", tick_out, 3'b000);
      checkOutput("midreset sq", sq_out, 3'b000);
      checkOutput("midreset pend", pend_out, 3'b000);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         nextCycle();
         expTick = (k % 4 == 0) ? 3'b111 : 3'b000;
         expSq   = ((k / 4) % 2 == 1) ? 3'b111 : 3'b000;
         checkOutput($sformatf("postreset tick k=%0d", k), tick_out, expTick);
         checkOutput($sformatf("postreset sq k=%0d", k), sq_out, expSq);
         checkOutput($sformatf("postreset pend k=%0d", k), pend_out, 3'b000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
